// File: rtl/gpu_pkg.sv
// Shared FPU-issue definitions: opcode map, opcode legality check and issue FSM states.
package gpu_pkg;

  localparam int unsigned FPU_OPC_W = 6;

  localparam logic [FPU_OPC_W-1:0] FPU_OP_ADD  = 6'd14;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_SUB  = 6'd15;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_MUL  = 6'd16;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_DIV  = 6'd17;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_SQRT = 6'd18;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_SIN  = 6'd19;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_COS  = 6'd20;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_TAN  = 6'd21;
  localparam logic [FPU_OPC_W-1:0] FPU_OP_LOG  = 6'd22;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } issue_state_e;

  function automatic logic is_fpu_op(input logic [FPU_OPC_W-1:0] opc);
    return (opc >= FPU_OP_ADD) && (opc <= FPU_OP_LOG);
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so pointers wrap freely.
module gpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_fpu_issue.sv
// Scheduler-to-FPU issue stage: registers ops, tags them with rd, pairs in-order results for writeback.
// Optional GPU_FPU_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module gpu_fpu_issue
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_W = 33,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FPU_OPC_W-1:0] req_opc,
  input  logic [DATA_W-1:0]    req_a,
  input  logic [DATA_W-1:0]    req_b,
  input  logic [REG_W-1:0]     req_rd,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 fpu_valid,
  input  logic                 fpu_ready,
  output logic [FPU_OPC_W-1:0] fpu_opc,
  output logic [DATA_W-1:0]    fpu_in1,
  output logic [DATA_W-1:0]    fpu_in2,
  input  logic                 fpu_rsp_valid,
  input  logic [DATA_W-1:0]    fpu_rsp_data,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REG_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]    wb_data,
`ifdef GPU_FPU_ISSUE_PERF_EN
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall,
`endif
  output logic                 err_opc
);

  issue_state_e state_q;
  logic         iss_v_q;
  logic         accept, accept_op, fire, wb_fire;
  logic         tag_full, tag_empty, res_full, res_empty;
  logic [$clog2(DEPTH):0] tag_count, res_count;
  logic [REG_W-1:0]       tag_head;
  logic [DATA_W-1:0]      res_head;
  logic                   unused_fifo;

  // Reset gates req_ready so every output reads 0 while reset is held.
  assign req_ready = !reset && (state_q == StRun) && !tag_full && (!iss_v_q || fpu_ready);
  assign accept    = req_valid && req_ready;
  assign accept_op = accept && is_fpu_op(req_opc);
  assign fire      = iss_v_q && fpu_ready;
  assign fpu_valid = iss_v_q;
  assign wb_valid  = !res_empty;
  assign wb_fire   = wb_valid && wb_ready;
  assign wb_rd     = wb_valid ? tag_head : '0;
  assign wb_data   = wb_valid ? res_head : '0;

  assign unused_fifo = ^{tag_count, res_count, res_full};

  gpu_sync_fifo #(
    .WIDTH(REG_W),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept_op),
    .push_data(req_rd),
    .pop      (wb_fire),
    .pop_data (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  // Result FIFO cannot overflow: every result has a tag already counted against DEPTH.
  gpu_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fpu_rsp_valid),
    .push_data(fpu_rsp_data),
    .pop      (wb_fire),
    .pop_data (res_head),
    .full     (res_full),
    .empty    (res_empty),
    .count    (res_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_v_q <= 1'b0;
      fpu_opc <= '0;
      fpu_in1 <= '0;
      fpu_in2 <= '0;
    end else if (accept_op) begin
      iss_v_q <= 1'b1;
      fpu_opc <= req_opc;
      fpu_in1 <= req_a;
      fpu_in2 <= req_b;
    end else if (fire) begin
      iss_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_opc <= 1'b0;
    end else if (accept && !is_fpu_op(req_opc)) begin
      err_opc <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state_q)
        StRun: begin
          if (flush) state_q <= StDrain;
        end
        StDrain: begin
          if (!flush) begin
            state_q <= StRun;
          end else if (!iss_v_q && tag_empty) begin
            state_q    <= StDone;
            flush_done <= 1'b1;
          end
        end
        StDone: begin
          if (!flush) begin
            state_q <= StRun;
          end else begin
            flush_done <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef GPU_FPU_ISSUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire) perf_issued <= perf_issued + 32'd1;
      if (req_valid && !req_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_fpu_issue.sv
// Bench for gpu_fpu_issue: fixed 3-cycle FPU model, scoreboard of tagged results, directed and random ops.
module tb_gpu_fpu_issue;

  localparam int unsigned DATA_W = 33;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic [5:0]        req_opc;
  logic [DATA_W-1:0] req_a, req_b;
  logic [REG_W-1:0]  req_rd;
  logic              flush, flush_done;
  logic              fpu_valid, fpu_ready;
  logic [5:0]        fpu_opc;
  logic [DATA_W-1:0] fpu_in1, fpu_in2;
  logic              fpu_rsp_valid;
  logic [DATA_W-1:0] fpu_rsp_data;
  logic              wb_valid, wb_ready;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err_opc;
`ifdef GPU_FPU_ISSUE_PERF_EN
  logic [31:0]       perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  gpu_fpu_issue #(
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opc      (req_opc),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .flush        (flush),
    .flush_done   (flush_done),
    .fpu_valid    (fpu_valid),
    .fpu_ready    (fpu_ready),
    .fpu_opc      (fpu_opc),
    .fpu_in1      (fpu_in1),
    .fpu_in2      (fpu_in2),
    .fpu_rsp_valid(fpu_rsp_valid),
    .fpu_rsp_data (fpu_rsp_data),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
`ifdef GPU_FPU_ISSUE_PERF_EN
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall),
`endif
    .err_opc      (err_opc)
  );

  typedef struct packed {logic [5:0] opc; logic [DATA_W-1:0] a; logic [DATA_W-1:0] b;} op_t;
  typedef struct packed {logic [REG_W-1:0] rd; logic [DATA_W-1:0] data;} wb_t;
  typedef struct packed {int due; logic [DATA_W-1:0] data;} rsp_t;

  op_t  exp_iss[$];
  wb_t  exp_wb[$];
  rsp_t fpu_pipe[$];
  logic [REG_W-1:0] wb_log[$];

  int checks = 0, failures = 0;
  int cyc = 0, n_acc = 0, n_fire = 0, n_wb = 0, sb_bad = 0, occ_bad = 0;
  int last_acc_cyc = 0, last_fire_cyc = 0, last_wb_cyc = 0;
  logic [REG_W-1:0]  last_wb_rd;
  logic [DATA_W-1:0] last_wb_data;

  function automatic bit ref_legal(input logic [5:0] opc);
    return (opc >= 6'd14) && (opc <= 6'd22);
  endfunction

  // Stand-in FPU arithmetic: one real float sum, otherwise a deterministic mix; bit 32 follows in1.
  function automatic logic [DATA_W-1:0] ref_fpu(input logic [5:0] opc, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    if (opc == 6'd14 && a[31:0] == 32'h3F80_0000 && b[31:0] == 32'h4000_0000)
      return 33'h0_4040_0000;
    return {a[32], (a[31:0] ^ {b[15:0], b[31:16]}) + {26'd0, opc}};
  endfunction

  // Monitor: records accepts, FPU fires and writebacks, scoring them against the expected queues.
  initial begin
    op_t o;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_iss.delete();
        exp_wb.delete();
        fpu_pipe.delete();
      end else begin
        cyc++;
        if (req_valid && req_ready) begin
          n_acc++;
          last_acc_cyc = cyc;
          if (ref_legal(req_opc)) begin
            exp_iss.push_back('{opc: req_opc, a: req_a, b: req_b});
            exp_wb.push_back('{rd: req_rd, data: ref_fpu(req_opc, req_a, req_b)});
          end
        end
        if (fpu_valid && fpu_ready) begin
          n_fire++;
          last_fire_cyc = cyc;
          o = '{opc: fpu_opc, a: fpu_in1, b: fpu_in2};
          if (exp_iss.size() == 0) sb_bad++;
          else if (o !== exp_iss[0]) begin sb_bad++; void'(exp_iss.pop_front()); end
          else void'(exp_iss.pop_front());
          fpu_pipe.push_back('{due: cyc + 2, data: ref_fpu(fpu_opc, fpu_in1, fpu_in2)});
        end
        if (wb_valid && wb_ready) begin
          n_wb++;
          last_wb_cyc  = cyc;
          last_wb_rd   = wb_rd;
          last_wb_data = wb_data;
          wb_log.push_back(wb_rd);
          if (exp_wb.size() == 0) sb_bad++;
          else begin
            if (exp_wb[0].rd !== wb_rd || exp_wb[0].data !== wb_data) sb_bad++;
            void'(exp_wb.pop_front());
          end
        end
        if (exp_wb.size() > DEPTH) occ_bad++;
      end
    end
  end

  // FPU model: fixed 3-cycle latency from fire to result pulse, strictly in order.
  initial begin
    fpu_rsp_valid = 1'b0;
    fpu_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && fpu_pipe.size() > 0 && fpu_pipe[0].due == cyc) begin
        fpu_rsp_valid = 1'b1;
        fpu_rsp_data  = fpu_pipe[0].data;
        void'(fpu_pipe.pop_front());
      end else begin
        fpu_rsp_valid = 1'b0;
        fpu_rsp_data  = '0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [5:0] opc, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [REG_W-1:0] rd, input bit rnd, output bit ok);
    req_valid = 1'b1;
    req_opc   = opc;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    ok        = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rnd) begin
        fpu_ready = ($urandom_range(0, 3) != 0);
        wb_ready  = ($urandom_range(0, 2) != 0);
      end
      #1;
      ok = req_ready;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = (exp_wb.size() == 0) && (exp_iss.size() == 0) && (fpu_pipe.size() == 0);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_opc = '0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; fpu_ready = 1'b1; wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, fpu_valid, wb_valid, flush_done, err_opc} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000", {req_ready, fpu_valid, wb_valid, flush_done, err_opc});
    end
    checks++;
    if ({fpu_opc, fpu_in1, fpu_in2, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: got opc=%0d in1=%h in2=%h rd=%0d data=%h want all 0",
               fpu_opc, fpu_in1, fpu_in2, wb_rd, wb_data);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok, idle;
    int acc_c;
    fpu_ready = 1'b1; wb_ready = 1'b1;
    send(6'd14, 33'h0_3F80_0000, 33'h0_4000_0000, 5'd7, 1'b0, ok);
    acc_c = last_acc_cyc;
    #1;
    checks++;
    if (!ok || fpu_valid !== 1'b1 || fpu_opc !== 6'd14 || fpu_in1 !== 33'h0_3F80_0000 ||
        fpu_in2 !== 33'h0_4000_0000) begin
      failures++;
      $display("FAIL basic_issue: got ok=%0b v=%b opc=%0d in1=%h in2=%h want 1 1 14 03f800000 040000000",
               ok, fpu_valid, fpu_opc, fpu_in1, fpu_in2);
    end
    wait_idle(50, idle);
    checks++;
    if (!idle || last_wb_rd !== 5'd7 || last_wb_data !== 33'h0_4040_0000) begin
      failures++;
      $display("FAIL basic_wb: got idle=%0b rd=%0d data=%h want 1 7 040400000", idle, last_wb_rd,
               last_wb_data);
    end
    checks++;
    if (last_wb_cyc - acc_c != 5) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 5", last_wb_cyc - acc_c);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok, idle;
    int first_acc, acc0, log0, bad0;
    fpu_ready = 1'b1; wb_ready = 1'b0;
    all_ok = 1'b1; log0 = wb_log.size(); bad0 = sb_bad;
    for (int i = 1; i <= 4; i++) begin
      send(6'($urandom_range(14, 22)), rnd_data(), rnd_data(), 5'(i), 1'b0, ok);
      all_ok &= ok;
      if (i == 1) first_acc = last_acc_cyc;
    end
    checks++;
    if (!all_ok || last_acc_cyc - first_acc != 3) begin
      failures++;
      $display("FAIL b2b_accept: got ok=%0b span=%0d want 1 3", all_ok, last_acc_cyc - first_acc);
    end
    req_valid = 1'b1; req_opc = 6'd15; req_a = rnd_data(); req_b = rnd_data(); req_rd = 5'd5;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b want 0", req_ready);
    end
    acc0 = n_acc;
    repeat (8) @(negedge clk);
    checks++;
    if (n_acc != acc0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_holdoff: got accepts=%0d wb_valid=%b want %0d 1", n_acc, wb_valid, acc0);
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc == acc0; i++) @(negedge clk);
    req_valid = 1'b0;
    wait_idle(60, idle);
    checks++;
    if (!idle || wb_log.size() != log0 + 5 || wb_log[log0] !== 5'd1 || wb_log[log0+1] !== 5'd2 ||
        wb_log[log0+2] !== 5'd3 || wb_log[log0+3] !== 5'd4 || wb_log[log0+4] !== 5'd5) begin
      failures++;
      $display("FAIL full_order: got idle=%0b n=%0d want rd order 1,2,3,4,5", idle,
               wb_log.size() - log0);
    end
    checks++;
    if (sb_bad != bad0) begin
      failures++;
      $display("FAIL full_scoreboard: got %0d mismatches want 0", sb_bad - bad0);
    end
  endtask

  task automatic test_stall();
    bit ok, stable, idle;
    int fire0, acc0, bad0;
    op_t a_op;
    fpu_ready = 1'b0; wb_ready = 1'b1; bad0 = sb_bad;
    a_op = '{opc: 6'd17, a: rnd_data(), b: rnd_data()};
    send(a_op.opc, a_op.a, a_op.b, 5'd9, 1'b0, ok);
    fire0 = n_fire; acc0 = n_acc; stable = ok;
    req_valid = 1'b1; req_opc = 6'd18; req_a = rnd_data(); req_b = rnd_data(); req_rd = 5'd10;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fpu_valid !== 1'b1 || fpu_opc !== a_op.opc || fpu_in1 !== a_op.a || fpu_in2 !== a_op.b ||
          req_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL stall_hold: got opc=%0d in1=%h in2=%h ready=%b want opc=%0d held, ready 0",
               fpu_opc, fpu_in1, fpu_in2, req_ready, a_op.opc);
    end
    checks++;
    if (n_fire != fire0 || n_acc != acc0) begin
      failures++;
      $display("FAIL stall_no_issue: got fires=%0d accepts=%0d want %0d %0d", n_fire, n_acc, fire0, acc0);
    end
    fpu_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (n_fire != fire0 + 1 || last_fire_cyc != cyc || n_acc != acc0 + 1) begin
      failures++;
      $display("FAIL stall_release: got fires=%0d accepts=%0d want %0d %0d", n_fire, n_acc,
               fire0 + 1, acc0 + 1);
    end
    wait_idle(50, idle);
    checks++;
    if (!idle || sb_bad != bad0) begin
      failures++;
      $display("FAIL stall_scoreboard: got idle=%0b mismatches=%0d want 1 0", idle, sb_bad - bad0);
    end
  endtask

  task automatic test_illegal();
    bit ok, saw_valid, idle;
    int wb0, fire0, bad0;
    logic [DATA_W-1:0] ma, mb;
    fpu_ready = 1'b1; wb_ready = 1'b1;
    wb0 = n_wb; fire0 = n_fire; bad0 = sb_bad; saw_valid = 1'b0;
    send(6'd5, rnd_data(), rnd_data(), 5'd3, 1'b0, ok);
    #1;
    checks++;
    if (!ok || err_opc !== 1'b1 || fpu_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_flag: got ok=%0b err=%b fpu_valid=%b want 1 1 0", ok, err_opc, fpu_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fpu_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid || n_wb != wb0 || n_fire != fire0 || err_opc !== 1'b1) begin
      failures++;
      $display("FAIL illegal_quiet: got issue=%0b wbs=%0d err=%b want 0 0 1", saw_valid, n_wb - wb0,
               err_opc);
    end
    ma = rnd_data(); mb = rnd_data();
    send(6'd16, ma, mb, 5'd12, 1'b0, ok);
    wait_idle(50, idle);
    checks++;
    if (!idle || last_wb_rd !== 5'd12 || last_wb_data !== ref_fpu(6'd16, ma, mb) || sb_bad != bad0 ||
        err_opc !== 1'b1) begin
      failures++;
      $display("FAIL illegal_then_mul: got rd=%0d data=%h err=%b want 12 %h 1", last_wb_rd,
               last_wb_data, err_opc, ref_fpu(6'd16, ma, mb));
    end
  endtask

  task automatic test_flush();
    bit ok1, ok2, early, seen;
    int wb0, acc0;
    fpu_ready = 1'b1; wb_ready = 1'b0; wb0 = n_wb; early = 1'b0; seen = 1'b0;
    send(6'd19, rnd_data(), rnd_data(), 5'd20, 1'b0, ok1);
    send(6'd20, rnd_data(), rnd_data(), 5'd21, 1'b0, ok2);
    flush = 1'b1;
    @(negedge clk);
    acc0 = n_acc;
    req_valid = 1'b1; req_opc = 6'd14; req_a = rnd_data(); req_b = rnd_data(); req_rd = 5'd22;
    #1;
    checks++;
    if (!(ok1 && ok2) || req_ready !== 1'b0 || flush_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_block: got ready=%b done=%b want 0 0", req_ready, flush_done);
    end
    repeat (6) begin
      @(negedge clk);
      #1;
      if (flush_done) early = 1'b1;
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (flush_done) begin
        seen = 1'b1;
        if (n_wb != wb0 + 2) early = 1'b1;
      end
    end
    checks++;
    if (!seen || early || n_wb != wb0 + 2 || n_acc != acc0) begin
      failures++;
      $display("FAIL flush_done: got seen=%0b early=%0b wbs=%0d accepts=%0d want 1 0 2 %0d", seen,
               early, n_wb - wb0, n_acc, acc0);
    end
    req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || flush_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_exit: got ready=%b done=%b want 1 0", req_ready, flush_done);
    end
  endtask

  task automatic test_random();
    bit ok, all_ok, idle;
    int wb0, bad0, legal;
    logic [5:0] opc;
    wb0 = n_wb; bad0 = sb_bad; legal = 0; all_ok = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        fpu_ready = ($urandom_range(0, 3) != 0);
        wb_ready  = ($urandom_range(0, 2) != 0);
        @(negedge clk);
      end
      if ($urandom_range(0, 7) == 0) opc = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 13))
                                                                        : 6'($urandom_range(23, 63));
      else opc = 6'($urandom_range(14, 22));
      if (ref_legal(opc)) legal++;
      send(opc, rnd_data(), rnd_data(), 5'($urandom), 1'b1, ok);
      all_ok &= ok;
    end
    fpu_ready = 1'b1; wb_ready = 1'b1;
    wait_idle(100, idle);
    checks++;
    if (!all_ok || !idle || n_wb - wb0 != legal) begin
      failures++;
      $display("FAIL random_count: got ok=%0b idle=%0b wbs=%0d want 1 1 %0d", all_ok, idle, n_wb - wb0,
               legal);
    end
    checks++;
    if (sb_bad != bad0 || occ_bad != 0) begin
      failures++;
      $display("FAIL random_scoreboard: got mismatches=%0d overfill=%0d want 0 0", sb_bad - bad0, occ_bad);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok, idle;
    logic [DATA_W-1:0] ra, rb;
    fpu_ready = 1'b1; wb_ready = 1'b0; all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(6'd21, rnd_data(), rnd_data(), 5'(24 + i), 1'b0, ok);
      all_ok &= ok;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (!all_ok || {req_ready, fpu_valid, wb_valid, flush_done, err_opc} !== 5'b0 ||
        {fpu_opc, fpu_in1, fpu_in2, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got ctrl=%b rd=%0d data=%h want 00000 0 0",
               {req_ready, fpu_valid, wb_valid, flush_done, err_opc}, wb_rd, wb_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wb_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0 || fpu_valid !== 1'b0 || req_ready !== 1'b1 || err_opc !== 1'b0) begin
      failures++;
      $display("FAIL midreset_empty: got wb_valid=%b fpu_valid=%b ready=%b err=%b want 0 0 1 0",
               wb_valid, fpu_valid, req_ready, err_opc);
    end
    @(negedge clk);
    ra = rnd_data(); rb = rnd_data();
    send(6'd22, ra, rb, 5'd30, 1'b0, ok);
    wait_idle(50, idle);
    checks++;
    if (!ok || !idle || last_wb_rd !== 5'd30 || last_wb_data !== ref_fpu(6'd22, ra, rb)) begin
      failures++;
      $display("FAIL midreset_after: got rd=%0d data=%h want 30 %h", last_wb_rd, last_wb_data,
               ref_fpu(6'd22, ra, rb));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
